// File: rtl/io_cycle_ctrl.sv
// io_cycle_ctrl: Z80 I/O bus-cycle controller downstream of the I/O decoder.
// Latches the decoder chip selects for the whole I/O cycle, generates the
// qualified read/write strobes, the interrupt-acknowledge strobe, a one-clock
// write-end pulse and optional programmable wait states for the FDC and 8251.
//
// Build option: define IO_WAIT_EN to build the wait counter and drive nWAIT;
// without it nWAIT is tied high and every access skips straight to HOLD.
//
// Parameters:
//   WAIT_FDC  wait cycles when nCSFDC is selected (0..15)
//   WAIT_51   wait cycles when nCS51 is selected (0..15)
// Ports:
//   clk, rst                          clock, async active-high reset
//   nIORQ, nRD, nWR, nM1              Z80 control strobes (active-low)
//   nCFE, nCF7, nCS55, nCSFDC,
//   nCS51, nCF1                       decoder chip selects (active-low)
//   nCS_Q[5:0]                        latched {nCF1,nCS51,nCSFDC,nCS55,nCF7,nCFE}
//   nIORD, nIOWR                      qualified I/O read/write (active-low)
//   nINTA                             interrupt acknowledge (active-low)
//   WR_STB                            one-clk pulse at the end of a write cycle
//   nWAIT                             wait request to the CPU (active-low)
module io_cycle_ctrl #(
  parameter int unsigned WAIT_FDC = 3,
  parameter int unsigned WAIT_51  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nIORQ,
  input  logic       nRD,
  input  logic       nWR,
  input  logic       nM1,
  input  logic       nCFE,
  input  logic       nCF7,
  input  logic       nCS55,
  input  logic       nCSFDC,
  input  logic       nCS51,
  input  logic       nCF1,
  output logic [5:0] nCS_Q,
  output logic       nIORD,
  output logic       nIOWR,
  output logic       nINTA,
  output logic       WR_STB,
  output logic       nWAIT
);

  localparam int unsigned CsWidth  = 6;
  localparam int unsigned CntWidth = 4;
  localparam logic [CsWidth-1:0] CsIdle = 6'h3F;

  // Reject wait counts that do not fit the 4-bit counter.
  if (WAIT_FDC > 15 || WAIT_51 > 15) begin : gBadWaitCfg
    $error("io_cycle_ctrl: WAIT_FDC and WAIT_51 must be in 0..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    INTA   = 2'd3
  } stateT;

  stateT              state, stateNext;
  logic [CsWidth-1:0] csNext;
  logic               rdNext, wrNext, intaNext, stbNext;
  logic [CsWidth-1:0] csIn;

  assign csIn = {nCF1, nCS51, nCSFDC, nCS55, nCF7, nCFE};

`ifdef IO_WAIT_EN
  logic [CntWidth-1:0] cnt, cntNext, waitLoad;
  logic                nWaitQ, waitNext;

  // Wait count for the device being selected; FDC wins over the 8251.
  always_comb begin
    waitLoad = '0;
    if (!nCSFDC)     waitLoad = CntWidth'(WAIT_FDC);
    else if (!nCS51) waitLoad = CntWidth'(WAIT_51);
  end

  assign nWAIT = nWaitQ;
`else
  assign nWAIT = 1'b1;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      nCS_Q  <= CsIdle;
      nIORD  <= 1'b1;
      nIOWR  <= 1'b1;
      nINTA  <= 1'b1;
      WR_STB <= 1'b0;
`ifdef IO_WAIT_EN
      cnt    <= '0;
      nWaitQ <= 1'b1;
`endif
    end else begin
      state  <= stateNext;
      nCS_Q  <= csNext;
      nIORD  <= rdNext;
      nIOWR  <= wrNext;
      nINTA  <= intaNext;
      WR_STB <= stbNext;
`ifdef IO_WAIT_EN
      cnt    <= cntNext;
      nWaitQ <= waitNext;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext = state;
    csNext    = nCS_Q;
    rdNext    = nIORD;
    wrNext    = nIOWR;
    intaNext  = nINTA;
    stbNext   = 1'b0;
`ifdef IO_WAIT_EN
    cntNext   = cnt;
    waitNext  = nWaitQ;
`endif

    unique case (state)
      IDLE: begin
        if (!nIORQ) begin
          if (!nM1) begin
            stateNext = INTA;
            intaNext  = 1'b0;
          end else if (nRD ^ nWR) begin
            // Exactly one of RD/WR low; both low is ignored as illegal.
            stateNext = ACCESS;
            csNext    = csIn;
            rdNext    = nRD;
            wrNext    = nWR;
`ifdef IO_WAIT_EN
            cntNext   = waitLoad;
            waitNext  = (waitLoad == '0);
`endif
          end
        end
      end

      ACCESS: begin
        if (nIORQ) begin
          // CPU dropped IORQ before the access completed: abort, no write pulse.
          stateNext = IDLE;
          csNext    = CsIdle;
          rdNext    = 1'b1;
          wrNext    = 1'b1;
`ifdef IO_WAIT_EN
          cntNext   = '0;
          waitNext  = 1'b1;
`endif
        end else begin
`ifdef IO_WAIT_EN
          if (cnt != '0) begin
            // nWAIT releases on the edge that brings the counter to zero.
            cntNext  = cnt - CntWidth'(1);
            waitNext = (cnt == CntWidth'(1));
          end else begin
            waitNext  = 1'b1;
            stateNext = HOLD;
          end
`else
          stateNext = HOLD;
`endif
        end
      end

      HOLD: begin
        if (nIORQ) begin
          stateNext = IDLE;
          csNext    = CsIdle;
          rdNext    = 1'b1;
          wrNext    = 1'b1;
          stbNext   = ~nIOWR;
        end
      end

      INTA: begin
        if (nIORQ) begin
          stateNext = IDLE;
          intaNext  = 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_cycle_ctrl.sv
// Directed testbench for io_cycle_ctrl: a vector table of per-clock inputs and
// expected registered outputs, plus hand-written FDC wait, abort and reset
// sequences. Works with or without IO_WAIT_EN defined.
module tb_io_cycle_ctrl;

`ifdef IO_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nM1 = 1'b1;
  logic [5:0] cs = 6'h3F;   // {nCF1,nCS51,nCSFDC,nCS55,nCF7,nCFE}
  logic [5:0] nCS_Q;
  logic       nIORD, nIOWR, nINTA, WR_STB, nWAIT;

  int passCnt  = 0;
  int totalCnt = 0;

  io_cycle_ctrl #(.WAIT_FDC(3), .WAIT_51(1)) dut (
    .clk(clk), .rst(rst),
    .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .nCFE(cs[0]), .nCF7(cs[1]), .nCS55(cs[2]),
    .nCSFDC(cs[3]), .nCS51(cs[4]), .nCF1(cs[5]),
    .nCS_Q(nCS_Q), .nIORD(nIORD), .nIOWR(nIOWR), .nINTA(nINTA),
    .WR_STB(WR_STB), .nWAIT(nWAIT)
  );

  always #5 clk = ~clk;

  // ctl = {nIORQ,nRD,nWR,nM1}; eo = {nIORD,nIOWR,nINTA,WR_STB,nWAIT-with-waits}
  typedef struct {
    logic [3:0] ctl;
    logic [5:0] cs;
    logic [5:0] eCs;
    logic [4:0] eo;
  } vecT;

  vecT vecs[23];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chkAll(input string tag, input logic [5:0] eCs, input logic eRd,
                        input logic eWr, input logic eInta, input logic eStb,
                        input logic eWait);
    chk({tag, " nCS_Q"},  8'(nCS_Q),  8'(eCs));
    chk({tag, " nIORD"},  8'(nIORD),  8'(eRd));
    chk({tag, " nIOWR"},  8'(nIOWR),  8'(eWr));
    chk({tag, " nINTA"},  8'(nINTA),  8'(eInta));
    chk({tag, " WR_STB"}, 8'(WR_STB), 8'(eStb));
    chk({tag, " nWAIT"},  8'(nWAIT),  8'(eWait));
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [5:0] c);
    {nIORQ, nRD, nWR, nM1} = ctl;
    cs = c;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Write to FE: strobe held until IORQ release, then one WR_STB pulse.
    vecs[0]  = '{4'b1111, 6'h3F, 6'h3F, 5'b11101};
    vecs[1]  = '{4'b0101, 6'h3E, 6'h3E, 5'b10101};
    vecs[2]  = '{4'b0101, 6'h3E, 6'h3E, 5'b10101};
    vecs[3]  = '{4'b0101, 6'h3E, 6'h3E, 5'b10101};
    vecs[4]  = '{4'b1111, 6'h3F, 6'h3F, 5'b11111};
    vecs[5]  = '{4'b1111, 6'h3F, 6'h3F, 5'b11101};
    // Interrupt acknowledge.
    vecs[6]  = '{4'b0110, 6'h3F, 6'h3F, 5'b11001};
    vecs[7]  = '{4'b0110, 6'h3F, 6'h3F, 5'b11001};
    vecs[8]  = '{4'b1111, 6'h3F, 6'h3F, 5'b11101};
    // 8251 read, decoder switches to nCS55 mid-cycle; latched select holds.
    vecs[9]  = '{4'b0011, 6'h2F, 6'h2F, 5'b01100};
    vecs[10] = '{4'b0011, 6'h3B, 6'h2F, 5'b01101};
    vecs[11] = '{4'b0011, 6'h3B, 6'h2F, 5'b01101};
    vecs[12] = '{4'b0011, 6'h3B, 6'h2F, 5'b01101};
    vecs[13] = '{4'b1111, 6'h3F, 6'h3F, 5'b11101};
    // Read with no select asserted still runs.
    vecs[14] = '{4'b0011, 6'h3F, 6'h3F, 5'b01101};
    vecs[15] = '{4'b1111, 6'h3F, 6'h3F, 5'b11101};
    // Illegal RD and WR both low: nothing happens.
    vecs[16] = '{4'b0001, 6'h3E, 6'h3F, 5'b11101};
    vecs[17] = '{4'b1111, 6'h3F, 6'h3F, 5'b11101};
    // Write aborted in ACCESS: no WR_STB; then back-to-back read.
    vecs[18] = '{4'b0101, 6'h3E, 6'h3E, 5'b10101};
    vecs[19] = '{4'b1111, 6'h3F, 6'h3F, 5'b11101};
    vecs[20] = '{4'b0011, 6'h3E, 6'h3E, 5'b01101};
    vecs[21] = '{4'b0011, 6'h3E, 6'h3E, 5'b01101};
    vecs[22] = '{4'b1111, 6'h3F, 6'h3F, 5'b11101};

    // Reset state.
    step();
    step();
    chkAll("reset", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].ctl, vecs[i].cs);
      step();
      chkAll($sformatf("vec%0d", i), vecs[i].eCs, vecs[i].eo[4], vecs[i].eo[3],
             vecs[i].eo[2], vecs[i].eo[1], WaitEn ? vecs[i].eo[0] : 1'b1);
    end

    // FDC read: nWAIT low for exactly 3 clocks when waits are built.
    drive(4'b0011, 6'h37);
    step();
    chkAll("fdc k", 6'h37, 1'b0, 1'b1, 1'b1, 1'b0, !WaitEn);
    for (int i = 1; i <= 4; i++) begin
      step();
      chkAll($sformatf("fdc k+%0d", i), 6'h37, 1'b0, 1'b1, 1'b1, 1'b0,
             WaitEn ? (i >= 3) : 1'b1);
    end
    drive(4'b1111, 6'h3F);
    step();
    chkAll("fdc rel", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chkAll("fdc idle", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // IORQ dropped while the FDC wait is running.
    drive(4'b0011, 6'h37);
    step();
    step();
    chk("abort nWAIT low", 8'(nWAIT), 8'(!WaitEn));
    drive(4'b1111, 6'h3F);
    step();
    chkAll("fdc abort", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset asserted mid-wait takes effect without a clock edge.
    drive(4'b0011, 6'h37);
    step();
    step();
    chk("pre-rst nIORD", 8'(nIORD), 8'(1'b0));
    #2 rst = 1'b1;
    #1;
    chkAll("async rst", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(4'b1111, 6'h3F);
    step();
    rst = 1'b0;
    drive(4'b0101, 6'h3E);
    step();
    chkAll("post-rst wr", 6'h3E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(4'b1111, 6'h3F);
    step();
    chkAll("post-rst stb", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("post-rst stb end", 8'(WR_STB), 8'(1'b0));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
